// File: rtl/linebuf_pkg.sv
// Shared types for the line-buffer controller: FSM encoding and border flag bit positions.
package linebuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int unsigned BORDER_W   = 4;
  localparam int unsigned BRD_TOP    = 3;
  localparam int unsigned BRD_BOTTOM = 2;
  localparam int unsigned BRD_LEFT   = 1;
  localparam int unsigned BRD_RIGHT  = 0;

endpackage

// File: rtl/linebuf_pos_cnt.sv
// Column/row position counter: column wraps at LENGTH-1 and carries into the row.
module linebuf_pos_cnt #(
  parameter int unsigned LENGTH    = 100,
  parameter int unsigned COL_WIDTH = 7,
  parameter int unsigned ROW_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 col_last_c
);

  assign col_last_c = (col == COL_WIDTH'(LENGTH - 1));

  // Clear has priority over advance; advance wraps the column and bumps the row.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_last_c) begin
        col <= '0;
        row <= row + ROW_WIDTH'(1);
      end else begin
        col <= col + COL_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/linebuf_ctrl.sv
// Frame sequencer in front of a 3-line buffer: forwards pixels, pads the last line,
// and tags the buffer's window outputs with position and border flags.
module linebuf_ctrl
  import linebuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 100,
  parameter int unsigned HEIGHT     = 100,
  parameter int unsigned COL_WIDTH  = 7,
  parameter int unsigned ROW_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_valid,
  input  logic                  buf_out_valid,
  output logic                  win_valid,
  output logic [ROW_WIDTH-1:0]  win_row,
  output logic [COL_WIDTH-1:0]  win_col,
  output logic [3:0]            border,
  output logic                  frame_done,
  output logic                  err_sof
);

  state_t state_q, state_d;

  logic [COL_WIDTH-1:0] in_col, out_col;
  logic [ROW_WIDTH-1:0] in_row, out_row;
  logic                 in_col_last, out_col_last;
  logic                 in_clr, in_inc, out_clr, out_inc;
  logic                 last_pix_c, last_win_c;
  logic                 last_seen_q;
  logic                 err_sof_d;

  // Input position: next pixel to accept; during FLUSH it counts pad columns.
  linebuf_pos_cnt #(
    .LENGTH    (LENGTH),
    .COL_WIDTH (COL_WIDTH),
    .ROW_WIDTH (ROW_WIDTH)
  ) u_in_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (in_clr),
    .inc        (in_inc),
    .col        (in_col),
    .row        (in_row),
    .col_last_c (in_col_last)
  );

  // Output position: centre of the window currently on the buffer outputs.
  linebuf_pos_cnt #(
    .LENGTH    (LENGTH),
    .COL_WIDTH (COL_WIDTH),
    .ROW_WIDTH (ROW_WIDTH)
  ) u_out_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (out_clr),
    .inc        (out_inc),
    .col        (out_col),
    .row        (out_row),
    .col_last_c (out_col_last)
  );

  // The FILL->RUN cycle already carries the first window, so it is tagged too.
  assign win_valid  = !rst && buf_out_valid && (state_q != ST_IDLE);
  assign out_inc    = win_valid;
  assign out_clr    = (state_q == ST_IDLE);
  assign last_pix_c = (in_row == ROW_WIDTH'(HEIGHT - 1)) && in_col_last;
  assign last_win_c = win_valid && (out_row == ROW_WIDTH'(HEIGHT - 1)) && out_col_last;
  assign err_sof_d  = s_valid && s_sof && (state_q != ST_IDLE);

  assign win_row = out_row;
  assign win_col = out_col;
  assign border[BRD_TOP]    = (out_row == '0);
  assign border[BRD_BOTTOM] = (out_row == ROW_WIDTH'(HEIGHT - 1));
  assign border[BRD_LEFT]   = (out_col == '0);
  assign border[BRD_RIGHT]  = out_col_last;

  // Next-state and zero-latency pixel path.
  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    buf_valid = 1'b0;
    buf_data  = '0;
    in_clr    = 1'b0;
    in_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        in_clr  = 1'b1;
        if (s_valid && s_sof) begin
          buf_valid = 1'b1;
          buf_data  = s_data;
          in_clr    = 1'b0;
          in_inc    = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          buf_valid = 1'b1;
          buf_data  = s_data;
          in_inc    = 1'b1;
        end
        if (s_valid && last_pix_c) begin
          state_d = ST_FLUSH;
        end else if ((state_q == ST_FILL) && buf_out_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        buf_valid = 1'b1;
        in_inc    = 1'b1;
        if (in_col_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_seen_q || last_win_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      s_ready   = 1'b0;
      buf_valid = 1'b0;
    end
  end

  // State, last-window latch and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_seen_q <= 1'b0;
      frame_done  <= 1'b0;
      err_sof     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_seen_q <= (state_q == ST_IDLE) ? 1'b0 : (last_seen_q | last_win_c);
      frame_done  <= last_win_c;
      err_sof     <= err_sof_d;
    end
  end

endmodule
